// File: rtl/ifetch_queue_if.sv
// Signal bundle between ifetch_queue (master) and its environment (slave):
// control inputs, IR stage outputs and the instruction read bus.
interface ifetch_queue_if;
    logic        ce;
    logic        pc_load;
    logic [15:0] pc_in;
    logic        ir_take;
    logic [15:0] ir;
    logic        ir_valid;
    logic [15:0] ir_pc;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic [15:0] bus_din;
    logic        bus_rply;
    logic        fetch_err;

    modport master (
        input  ce, pc_load, pc_in, ir_take, bus_din, bus_rply,
        output ir, ir_valid, ir_pc, bus_addr, bus_rd, fetch_err
    );
    modport slave (
        output ce, pc_load, pc_in, ir_take, bus_din, bus_rply,
        input  ir, ir_valid, ir_pc, bus_addr, bus_rd, fetch_err
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: fetch PC, IR stage and optional one-word prefetch
// buffer (enabled by defining IFETCH_PREFETCH_EN), with bus timeout and odd-PC trap.
module ifetch_queue #(
    parameter int BUS_TMO = 15
) (
    input logic            clk,
    input logic            reset,
    ifetch_queue_if.master bif
);
    localparam int CW = (BUS_TMO < 1) ? 1 : $clog2(BUS_TMO + 1);

`ifdef IFETCH_PREFETCH_EN
    localparam bit PREF = 1'b1;
`else
    localparam bit PREF = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, STALL} state_t;

    state_t        state_q, state_d;
    logic [15:0]   fpc_q, fpc_d;
    logic [15:0]   ir_q, ir_d;
    logic [15:0]   ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;
    logic [15:0]   buf_q, buf_d;
    logic [15:0]   buf_pc_q, buf_pc_d;
    logic          buf_valid_q, buf_valid_d;
    logic [15:0]   bus_addr_q, bus_addr_d;
    logic          bus_rd_q, bus_rd_d;
    logic          fetch_err_q, fetch_err_d;
    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          take;
    logic          rply;
    logic          free;
    logic [CW-1:0] cnt_inc;
    logic [15:0]   rply_pc;

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        buf_d       = buf_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_rd_d    = bus_rd_q;
        run_d       = run_q;
        cnt_d       = cnt_q;
        fetch_err_d = 1'b0;

        take    = bif.ir_take & ir_valid_q;
        rply    = bus_rd_q & bif.bus_rply;
        cnt_inc = cnt_q + 1'b1;
        rply_pc = bus_addr_q + 16'd2;
        free    = 1'b0;

        if (bif.ce) begin
            if (bif.pc_load) begin
                fpc_d       = bif.pc_in;
                ir_valid_d  = 1'b0;
                buf_valid_d = 1'b0;
                bus_rd_d    = 1'b0;
                cnt_d       = '0;
                run_d       = 1'b1;
                state_d     = IDLE;
            end else begin
                if (take) begin
                    if (buf_valid_q) begin
                        ir_d        = buf_q;
                        ir_pc_d     = buf_pc_q;
                        buf_valid_d = 1'b0;
                    end else if (rply) begin
                        ir_d    = bif.bus_din;
                        ir_pc_d = rply_pc;
                    end else begin
                        ir_valid_d = 1'b0;
                    end
                end
                // The reply was not consumed straight into IR above: queue it behind IR.
                if (rply && !(take && !buf_valid_q)) begin
                    if (!ir_valid_q) begin
                        ir_d       = bif.bus_din;
                        ir_pc_d    = rply_pc;
                        ir_valid_d = 1'b1;
                    end else begin
                        buf_d       = bif.bus_din;
                        buf_pc_d    = rply_pc;
                        buf_valid_d = 1'b1;
                    end
                end
                if (rply) begin
                    fpc_d = fpc_q + 16'd2;
                end
`ifndef IFETCH_PREFETCH_EN
                buf_valid_d = 1'b0;
`endif
                free = !ir_valid_d || (PREF && !buf_valid_d);

                case (state_q)
                    IDLE: begin
                        if (run_q && free) begin
                            if (fpc_q[0]) begin
                                fetch_err_d = 1'b1;
                                state_d     = STALL;
                            end else begin
                                bus_addr_d = fpc_q;
                                bus_rd_d   = 1'b1;
                                cnt_d      = '0;
                                state_d    = READ;
                            end
                        end
                    end
                    READ: begin
                        if (rply) begin
                            if (free) begin
                                bus_addr_d = fpc_d;
                                cnt_d      = '0;
                            end else begin
                                bus_rd_d = 1'b0;
                                state_d  = IDLE;
                            end
                        end else if (cnt_inc == CW'(BUS_TMO)) begin
                            cnt_d       = cnt_inc;
                            bus_rd_d    = 1'b0;
                            fetch_err_d = 1'b1;
                            state_d     = STALL;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fpc_q       <= '0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            buf_q       <= '0;
            buf_pc_q    <= '0;
            buf_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_rd_q    <= 1'b0;
            fetch_err_q <= 1'b0;
            run_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            buf_q       <= buf_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_rd_q    <= bus_rd_d;
            fetch_err_q <= fetch_err_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bif.ir        = ir_q;
    assign bif.ir_pc     = ir_pc_q;
    assign bif.ir_valid  = ir_valid_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_rd    = bus_rd_q;
    assign bif.fetch_err = fetch_err_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus a scoreboard that tracks every
// accepted bus reply and checks the IR stage presents words in fetch order.
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic reset = 1'b0;

    ifetch_queue_if bif();
    ifetch_queue #(.BUS_TMO(15)) dut (.clk(clk), .reset(reset), .bif(bif));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] pc;
    } ent_t;

    ent_t sb[$];
    ent_t ent;
    int   vecs = 0;
    int   errs = 0;
    bit   half_rate = 1'b0;
    bit   mon_en = 1'b0;

    // Expected IR content is the oldest reply not yet taken or flushed.
    always @(negedge clk) begin
        if (mon_en) begin
            vecs++;
            if (bif.ir_valid !== (sb.size() != 0)) begin
                errs++;
                $display("FAIL sb_valid: ir_valid=%0b, expected %0b (queued=%0d) at %0t",
                         bif.ir_valid, (sb.size() != 0), sb.size(), $time);
            end else if (bif.ir_valid && (bif.ir !== sb[0].w || bif.ir_pc !== sb[0].pc)) begin
                errs++;
                $display("FAIL sb_order: ir=%o ir_pc=%o, expected ir=%o ir_pc=%o at %0t",
                         bif.ir, bif.ir_pc, sb[0].w, sb[0].pc, $time);
            end
            if (bif.ce) begin
                if (bif.pc_load) begin
                    sb.delete();
                end else begin
                    if (bif.ir_take && bif.ir_valid && sb.size() != 0) void'(sb.pop_front());
                    if (bif.bus_rply && bif.bus_rd) begin
                        ent.w  = bif.bus_din;
                        ent.pc = bif.bus_addr + 16'd2;
                        sb.push_back(ent);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bif.ce = 1'b1;
        cyc();
        if (half_rate) begin
            bif.ce = 1'b0;
            cyc();
            bif.ce = 1'b1;
        end
    endtask

    task automatic clr();
        bif.pc_load  = 1'b0;
        bif.ir_take  = 1'b0;
        bif.bus_rply = 1'b0;
    endtask

    task automatic load(input logic [15:0] pc);
        bif.pc_load = 1'b1;
        bif.pc_in   = pc;
        step();
        bif.pc_load = 1'b0;
    endtask

    task automatic reply(input logic [15:0] data);
        bif.bus_din  = data;
        bif.bus_rply = 1'b1;
        step();
        bif.bus_rply = 1'b0;
    endtask

    task automatic take();
        bif.ir_take = 1'b1;
        step();
        bif.ir_take = 1'b0;
    endtask

    task automatic wait_rd(output bit ok);
        int n = 0;
        while (!bif.bus_rd && n < 8) begin
            step();
            n++;
        end
        ok = bif.bus_rd;
    endtask

    task automatic test_reset();
        int rd_seen = 0;
        #2 reset = 1'b1;
        #1;
        vecs++;
        if ({bif.ir, bif.ir_pc, bif.bus_addr} !== 48'd0) begin
            errs++;
            $display("FAIL reset_words: ir=%o ir_pc=%o bus_addr=%o, expected all 0",
                     bif.ir, bif.ir_pc, bif.bus_addr);
        end
        vecs++;
        if ({bif.ir_valid, bif.bus_rd, bif.fetch_err} !== 3'b000) begin
            errs++;
            $display("FAIL reset_flags: ir_valid/bus_rd/fetch_err=%b, expected 000",
                     {bif.ir_valid, bif.bus_rd, bif.fetch_err});
        end
        repeat (2) cyc();
        reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bif.bus_rd) rd_seen++;
        end
        vecs++;
        if (rd_seen != 0) begin
            errs++;
            $display("FAIL no_fetch_before_load: bus_rd high %0d cycles, expected 0", rd_seen);
        end
    endtask

    task automatic test_basic();
        bit ok;
        load(16'o001000);
        wait_rd(ok);
        vecs++;
        if (!ok || bif.bus_addr !== 16'o001000) begin
            errs++;
            $display("FAIL basic_addr: bus_rd=%0b bus_addr=%o, expected 1 / 001000", ok, bif.bus_addr);
        end
        step();
        reply(16'o012700);
        vecs++;
        if ({bif.ir_valid, bif.ir, bif.ir_pc} !== {1'b1, 16'o012700, 16'o001002}) begin
            errs++;
            $display("FAIL basic_ir: valid=%0b ir=%o ir_pc=%o, expected 1 012700 001002",
                     bif.ir_valid, bif.ir, bif.ir_pc);
        end
        take();
    endtask

    task automatic test_prefetch();
        bit ok;
        load(16'o001000);
        wait_rd(ok);
        reply(16'o005001);
`ifdef IFETCH_PREFETCH_EN
        vecs++;
        if (bif.bus_rd !== 1'b1 || bif.bus_addr !== 16'o001002) begin
            errs++;
            $display("FAIL pf_second_read: bus_rd=%0b bus_addr=%o, expected 1 / 001002",
                     bif.bus_rd, bif.bus_addr);
        end
        reply(16'o005002);
        vecs++;
        if ({bif.bus_rd, bif.ir} !== {1'b0, 16'o005001}) begin
            errs++;
            $display("FAIL pf_full: bus_rd=%0b ir=%o, expected 0 / 005001", bif.bus_rd, bif.ir);
        end
        take();
`else
        vecs++;
        if (bif.bus_rd !== 1'b0) begin
            errs++;
            $display("FAIL nopf_hold: bus_rd=%0b with IR full, expected 0", bif.bus_rd);
        end
        take();
        wait_rd(ok);
        vecs++;
        if (!ok || bif.bus_addr !== 16'o001002) begin
            errs++;
            $display("FAIL nopf_next: bus_rd=%0b bus_addr=%o, expected 1 / 001002", ok, bif.bus_addr);
        end
        reply(16'o005002);
`endif
        vecs++;
        if ({bif.ir, bif.ir_pc} !== {16'o005002, 16'o001004}) begin
            errs++;
            $display("FAIL pf_advance: ir=%o ir_pc=%o, expected 005002 001004", bif.ir, bif.ir_pc);
        end
`ifndef IFETCH_PREFETCH_EN
        take();
`endif
        wait_rd(ok);
        vecs++;
        if (!ok || bif.bus_addr !== 16'o001004) begin
            errs++;
            $display("FAIL pf_third_read: bus_rd=%0b bus_addr=%o, expected 1 / 001004", ok, bif.bus_addr);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int hi = 0;
        int pulses = 0;
        load(16'o001000);
        wait_rd(ok);
        if (ok) hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bif.bus_rd) hi++;
            if (bif.fetch_err) pulses++;
        end
        vecs++;
        if (hi != 15) begin
            errs++;
            $display("FAIL tmo_len: bus_rd high %0d cycles, expected 15", hi);
        end
        vecs++;
        if (pulses != 1) begin
            errs++;
            $display("FAIL tmo_err: fetch_err pulsed %0d cycles, expected 1", pulses);
        end
    endtask

    task automatic test_odd_pc();
        int pulses = 0;
        int rd = 0;
        load(16'o000777);
        for (int i = 0; i < 8; i++) begin
            step();
            if (bif.fetch_err) pulses++;
            if (bif.bus_rd) rd++;
        end
        vecs++;
        if (pulses != 1 || rd != 0 || bif.ir_valid !== 1'b0) begin
            errs++;
            $display("FAIL odd_pc: fetch_err=%0d bus_rd=%0d ir_valid=%0b, expected 1 0 0",
                     pulses, rd, bif.ir_valid);
        end
    endtask

    task automatic test_flush_race();
        bit ok;
        load(16'o001000);
        wait_rd(ok);
        bif.bus_din  = 16'o000240;
        bif.bus_rply = 1'b1;
        bif.pc_load  = 1'b1;
        bif.pc_in    = 16'o002000;
        step();
        clr();
        vecs++;
        if ({bif.ir_valid, bif.bus_rd} !== 2'b00) begin
            errs++;
            $display("FAIL flush_drop: ir_valid=%0b bus_rd=%0b, expected 0 0", bif.ir_valid, bif.bus_rd);
        end
        wait_rd(ok);
        vecs++;
        if (!ok || bif.bus_addr !== 16'o002000) begin
            errs++;
            $display("FAIL flush_addr: bus_rd=%0b bus_addr=%o, expected 1 / 002000", ok, bif.bus_addr);
        end
        reply(16'o001234);
        bif.ir_take = 1'b1;
        bif.pc_load = 1'b1;
        bif.pc_in   = 16'o003000;
        step();
        clr();
        vecs++;
        if (bif.ir_valid !== 1'b0) begin
            errs++;
            $display("FAIL load_beats_take: ir_valid=%0b, expected 0", bif.ir_valid);
        end
    endtask

    task automatic test_wrap(input bit half);
        bit ok;
        int pulses = 0;
        half_rate = half;
        load(16'o177776);
        wait_rd(ok);
        vecs++;
        if (!ok || bif.bus_addr !== 16'o177776) begin
            errs++;
            $display("FAIL wrap_addr(half=%0b): bus_rd=%0b bus_addr=%o, expected 1 / 177776",
                     half, ok, bif.bus_addr);
        end
        reply(16'o000137);
        if (bif.fetch_err) pulses++;
        vecs++;
        if ({bif.ir_valid, bif.ir, bif.ir_pc} !== {1'b1, 16'o000137, 16'o000000}) begin
            errs++;
            $display("FAIL wrap_ir(half=%0b): valid=%0b ir=%o ir_pc=%o, expected 1 000137 000000",
                     half, bif.ir_valid, bif.ir, bif.ir_pc);
        end
        take();
        if (bif.fetch_err) pulses++;
        wait_rd(ok);
        vecs++;
        if (!ok || bif.bus_addr !== 16'o000000 || pulses != 0) begin
            errs++;
            $display("FAIL wrap_next(half=%0b): bus_rd=%0b bus_addr=%o err=%0d, expected 1 / 000000 / 0",
                     half, ok, bif.bus_addr, pulses);
        end
        half_rate = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_addr = 16'o004000;
        int words = 0;
        int stall_n = 0;
        load(16'o004000);
        for (int i = 0; i < 200; i++) begin
            bif.ir_take = 1'($urandom_range(0, 1));
            if (bif.bus_rd && ($urandom_range(0, 1) == 1 || stall_n >= 4)) begin
                vecs++;
                if (bif.bus_addr !== exp_addr) begin
                    errs++;
                    $display("FAIL stream_addr: bus_addr=%o, expected %o", bif.bus_addr, exp_addr);
                end
                exp_addr     = exp_addr + 16'd2;
                bif.bus_din  = 16'($urandom);
                bif.bus_rply = 1'b1;
                stall_n      = 0;
                words++;
            end else if (bif.bus_rd) begin
                stall_n++;
            end
            step();
            clr();
        end
        vecs++;
        if (words < 20) begin
            errs++;
            $display("FAIL stream_progress: %0d words fetched, expected at least 20", words);
        end
    endtask

    initial begin
        bif.ce      = 1'b1;
        bif.pc_in   = 16'd0;
        bif.bus_din = 16'd0;
        clr();
        test_reset();
        test_basic();
        test_prefetch();
        test_timeout();
        test_odd_pc();
        test_flush_race();
        test_wrap(1'b0);
        test_wrap(1'b1);
        test_back_to_back();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d miscompares so far", errs);
        $fatal(1);
    end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter: BUS_TMO, default 15, bus-read cycles without bus_rply before a fetch timeout.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ce  in  1  clock enable; state advances only when ce=1.
REQ-005 pc_load  in  1  load fetch PC (branch, trap, jump); flushes queue.
REQ-006 pc_in  in  16  new PC value, sampled when pc_load=1.
REQ-007 ir_take  in  1  consumer takes the current instruction word.
REQ-008 ir  out  16  instruction word; drives the decoder opcode input.
REQ-009 ir_valid  out  1  ir holds a valid word.
REQ-010 ir_pc  out  16  address following ir (PC value seen by the instruction).
REQ-011 bus_addr  out  16  fetch address.
REQ-012 bus_rd  out  1  read request, held until bus_rply, timeout or flush.
REQ-013 bus_din  in  16  read data, valid with bus_rply.
REQ-014 bus_rply  in  1  read acknowledge, one cycle.
REQ-015 fetch_err  out  1  one-cycle pulse: odd address or bus timeout.

Function
REQ-016 Internal: fetch PC fpc, IR stage (ir, ir_pc, ir_valid), one-word prefetch buffer (buf, buf_pc, buf_valid), timeout counter of width ceil(log2(BUS_TMO+1)).
REQ-017 FSM states: IDLE (no read), READ (bus_rd=1), STALL (error, waits for pc_load).
REQ-018 IDLE -> READ when a free slot exists (ir_valid=0, or buf_valid=0 with prefetch enabled) and fpc[0]=0; bus_addr=fpc.
REQ-019 READ, bus_rply=1: word goes to IR if IR empty or ir_take in same cycle, else to buf; fpc<=fpc+2 (wraps 177776->000000); return to IDLE, or stay READ if another slot is free.
REQ-020 IR stage: stored ir_pc = fetch address + 2, modulo 2^16.
REQ-021 ir_take with ir_valid=1: IR loads buf if buf_valid, else rply data if present that cycle, else ir_valid<=0; ir_take with ir_valid=0 ignored.
REQ-022 Words leave in fetch order; no word lost or duplicated.
REQ-023 Timeout: counter clears on entering READ and counts per ce cycle; at BUS_TMO with no rply -> bus_rd<=0, fetch_err pulse, STALL.
REQ-024 Odd fpc when a fetch would start: no bus cycle, fetch_err pulse, STALL.
REQ-025 pc_load (any state): fpc<=pc_in, ir_valid<=0, buf_valid<=0, bus_rd<=0 next cycle, counter cleared, state IDLE; bus_rply in the same cycle is discarded; pc_load wins over simultaneous ir_take.
REQ-026 STALL: ir_valid and buf already queued drain normally via ir_take; no new reads.
REQ-027 bus_addr stable while bus_rd=1; bus_rply while bus_rd=0 ignored.
REQ-028 ce=0: all registers hold, fetch_err not pulsed, counter frozen.
REQ-029 Best-case latency: pc_load at cycle N -> bus_rd at N+1 -> rply at N+k -> ir_valid at N+k+1.

Reset
REQ-030 reset=1 asynchronously: state IDLE, fpc=000000, ir=000000, ir_pc=000000, ir_valid=0, buf_valid=0, bus_rd=0, bus_addr=000000, fetch_err=0, counter=0.
REQ-031 After reset release no fetch starts until pc_load (core loads start vector).

Configuration
REQ-032 Macro IFETCH_PREFETCH_EN defined: prefetch buffer present; fetch of next word proceeds while ir_valid=1.
REQ-033 Macro undefined: buffer removed; fetch starts only when ir_valid=0 (or ir_take this cycle); buf_valid constant 0; all other requirements unchanged.

Verification
REQ-034 pc_load pc_in=001000, rply data 012700 after 2 cycles -> bus_addr=001000, ir=012700, ir_pc=001002, ir_valid=1.
REQ-035 Prefetch on, no ir_take, rplys 005001/005002 -> ir=005001, buf holds 005002, bus_rd=0; ir_take -> ir=005002, ir_pc=001004, new read at 001004.
REQ-036 bus_rply never returned, BUS_TMO=15 -> bus_rd drops after 15 ce cycles, fetch_err one pulse, STALL until pc_load.
REQ-037 pc_load pc_in=000777 -> no bus_rd, fetch_err pulse, ir_valid=0.
REQ-038 pc_load pc_in=002000 in same cycle as bus_rply of 000240 -> 000240 discarded, next bus_addr=002000.
REQ-039 fpc=177776, rply 000137 -> ir_pc=000000, next bus_addr=000000; repeat with ce toggling 1/0 -> identical results at half rate.
